// File: rtl/oq_pkg.sv
// Shared definitions for the output-queue PIFO writer.
// Holds default bus widths, the PIFO descriptor bit layout, the writer
// FSM state type and a helper that builds a descriptor from a rank.
package oq_pkg;

    localparam int C_DATA_WIDTH_DEF  = 256;
    localparam int C_TUSER_WIDTH_DEF = 128;
    localparam int RANK_WIDTH_DEF    = 19;
    localparam int PIFO_WIDTH        = 32;

    localparam int PIFO_VALID_BIT = 31;
    localparam int PIFO_RANK_LSB  = 12;
    localparam int PIFO_RANK_MSB  = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    // Descriptor layout: {valid, rank[18:0], 12'b0}.
    function automatic logic [PIFO_WIDTH-1:0] make_pifo(
        input logic [PIFO_RANK_MSB-PIFO_RANK_LSB:0] rank
    );
        logic [PIFO_WIDTH-1:0] desc;
        desc = 32'h0000_0000;
        desc[PIFO_VALID_BIT] = 1'b1;
        desc[PIFO_RANK_MSB:PIFO_RANK_LSB] = rank;
        return desc;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry AXI-stream register slice with a flat payload vector.
// Ports: clk/resetn (sync active-low reset), in_valid/in_data/in_ready
// upstream side, out_valid/out_data/out_ready downstream side.
// The slice loads whenever it is empty or being drained, so throughput
// is one beat per cycle while out_ready stays high.
module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Ready is forced low while reset is held so nothing is accepted.
    assign in_ready  = resetn & (~valid_q | out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state: load on free slot (data zeroed for bubbles), else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = {WIDTH{1'b0}};
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slice storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/oq_pifo_writer.sv
// Output-queue PIFO writer.
// Accepts packets on s_axis, decides on the first beat whether to forward
// (oq_almost_full=0) or drop (oq_almost_full=1) the whole packet, tags every
// forwarded beat with a PIFO descriptor built from the first-beat rank, and
// presents it on m_axis through one register stage.
// Ports: axis_aclk/axis_resetn (sync active-low), s_axis_* upstream stream
// plus s_axis_trank, oq_almost_full/oq_tready from the output queue,
// m_axis_* stream plus m_axis_tpifo, m_axis_buffer_wr_en,
// m_axis_pifo_insert_en, and pkt_count/drop_count statistics.
module oq_pifo_writer
    import oq_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int RANK_WIDTH    = 19
) (
    input  logic                      axis_aclk,
    input  logic                      axis_resetn,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    input  logic [RANK_WIDTH-1:0]     s_axis_trank,
    input  logic                      oq_almost_full,
    input  logic                      oq_tready,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [31:0]               m_axis_tpifo,
    output logic                      m_axis_buffer_wr_en,
    output logic                      m_axis_pifo_insert_en,
    output logic [31:0]               pkt_count,
    output logic [31:0]               drop_count
);

    localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;
    localparam int PAY_WIDTH  = C_DATA_WIDTH + KEEP_WIDTH + C_TUSER_WIDTH + PIFO_WIDTH + 2;

    wr_state_e             state_q;
    wr_state_e             state_d;
    logic [RANK_WIDTH-1:0] rank_q;
    logic [RANK_WIDTH-1:0] rank_d;
    logic [31:0]           pkt_count_q;
    logic [31:0]           pkt_count_d;
    logic [31:0]           drop_count_q;
    logic [31:0]           drop_count_d;

    logic                  accept_s;
    logic                  fwd_s;
    logic                  first_s;
    logic [RANK_WIDTH-1:0] beat_rank_s;
    logic                  pipe_ready_s;
    logic                  pipe_valid_s;
    logic [PAY_WIDTH-1:0]  pay_in_s;
    logic [PAY_WIDTH-1:0]  pay_out_s;

    // A beat is accepted only when the output slice can take it, so a
    // stalled output queue stalls the whole packet rather than losing beats.
    assign accept_s      = s_axis_tvalid & pipe_ready_s;
    assign s_axis_tready = pipe_ready_s;

    // Packet-level decision: forward/drop chosen on the start beat only.
    always_comb begin
        state_d      = state_q;
        rank_d       = rank_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        fwd_s        = 1'b0;
        first_s      = 1'b0;
        beat_rank_s  = rank_q;
        if (accept_s) begin
            case (state_q)
                IDLE: begin
                    if (oq_almost_full) begin
                        drop_count_d = drop_count_q + 32'd1;
                        state_d      = s_axis_tlast ? IDLE : DROP;
                    end else begin
                        // First beat uses the live rank; later beats the latched one.
                        fwd_s       = 1'b1;
                        first_s     = 1'b1;
                        rank_d      = s_axis_trank;
                        beat_rank_s = s_axis_trank;
                        if (s_axis_tlast) begin
                            pkt_count_d = pkt_count_q + 32'd1;
                            state_d     = IDLE;
                        end else begin
                            state_d = FWD;
                        end
                    end
                end
                FWD: begin
                    fwd_s = 1'b1;
                    if (s_axis_tlast) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        state_d     = IDLE;
                    end else begin
                        state_d = FWD;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state, latched rank and counters.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q      <= IDLE;
            rank_q       <= {RANK_WIDTH{1'b0}};
            pkt_count_q  <= 32'd0;
            drop_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            rank_q       <= rank_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pay_in_s = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast,
                       make_pifo(beat_rank_s), first_s};

    axis_pipe_reg #(
        .WIDTH (PAY_WIDTH)
    ) u_out_reg (
        .clk       (axis_aclk),
        .resetn    (axis_resetn),
        .in_valid  (fwd_s),
        .in_data   (pay_in_s),
        .in_ready  (pipe_ready_s),
        .out_valid (pipe_valid_s),
        .out_data  (pay_out_s),
        .out_ready (oq_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
            m_axis_tpifo, m_axis_pifo_insert_en} = pay_out_s;
    assign m_axis_tvalid       = pipe_valid_s;
    assign m_axis_buffer_wr_en = pipe_valid_s;
    assign pkt_count           = pkt_count_q;
    assign drop_count          = drop_count_q;

endmodule

// File: doc/oq_pifo_writer.md
OQ_PIFO_WRITER -- requirements
Module: oq_pifo_writer

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 256, data bus width.
REQ-002 SHALL have parameter C_TUSER_WIDTH, default 128, sideband width.
REQ-003 SHALL have parameter RANK_WIDTH, default 19, root rank width.
REQ-004 SHALL have port axis_aclk, input, 1, the single clock.
REQ-005 SHALL have port axis_resetn, input, 1; one clock; reset is synchronous and active-low.
REQ-006 SHALL have ports s_axis_tdata (C_DATA_WIDTH), s_axis_tkeep (C_DATA_WIDTH/8), s_axis_tuser (C_TUSER_WIDTH), s_axis_tvalid (1), s_axis_tlast (1), all inputs: the upstream packet stream.
REQ-007 SHALL have port s_axis_tready, output, 1, upstream backpressure.
REQ-008 SHALL have port s_axis_trank, input, RANK_WIDTH, packet rank, sampled on the first beat only.
REQ-009 SHALL have port oq_almost_full, input, 1, output-queue buffer almost-full.
REQ-010 SHALL have port oq_tready, input, 1, output-queue write-side ready.
REQ-011 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid and m_axis_tlast, all outputs, with widths as in REQ-006.
REQ-012 SHALL have port m_axis_tpifo, output, 32, PIFO descriptor {1'b1, rank[18:0], 12'b0}.
REQ-013 SHALL have ports m_axis_buffer_wr_en and m_axis_pifo_insert_en, outputs, 1 bit each.
REQ-014 SHALL have ports pkt_count and drop_count, outputs, 32 bits each: forwarded and dropped packet counters.

Function
REQ-015 SHALL implement an FSM with states IDLE, FWD and DROP.
- IDLE: the next accepted beat is a packet start.
REQ-016 In IDLE, a start beat with oq_almost_full=1 SHALL drop the packet.
- drop_count increments once.
- Next state is DROP, or stays IDLE if tlast=1.
- Nothing is emitted.
REQ-017 In IDLE, a start beat with oq_almost_full=0 SHALL forward the beat.
- Rank is latched.
- Next state is FWD, or stays IDLE if tlast=1.
REQ-018 In FWD, every accepted beat SHALL be forwarded.
- The latched rank is used for all beats.
- On tlast, pkt_count increments and the FSM returns to IDLE.
REQ-019 In DROP, beats SHALL be accepted and discarded until tlast, then the FSM returns to IDLE.
REQ-020 oq_almost_full SHALL be ignored after the first beat; a packet is never truncated.
REQ-021 Forwarded beats SHALL appear on m_axis exactly 1 cycle after acceptance, through a single output register stage.
- m_axis_buffer_wr_en equals m_axis_tvalid.
REQ-022 m_axis_pifo_insert_en SHALL be 1 only on the first output beat of a forwarded packet.
- This includes single-beat packets, where it is 1 together with tlast.
REQ-023 m_axis_tpifo SHALL be held constant for every beat of a packet.
REQ-024 s_axis_tready SHALL equal (~m_axis_tvalid | oq_tready).
- While oq_tready=0, the output register holds its contents and no beat is lost or duplicated.
REQ-025 Counters SHALL wrap modulo 2^32.
- For a single-beat packet, the packet-end increment and the FSM return occur in the same cycle.
REQ-026 A beat with tkeep=0 SHALL be forwarded unchanged.

Reset
REQ-027 While axis_resetn=0, the block SHALL hold:
- State IDLE.
- All m_axis_* outputs, pkt_count and drop_count at 0.
- s_axis_tready at 0.
- Latched rank at 0.
REQ-028 Reset mid-packet SHALL discard in-flight data; the first accepted beat after reset is treated as a packet start.

Structure
REQ-029 Package oq_pkg SHALL hold:
- The width constants.
- PIFO_VALID_BIT=31, PIFO_RANK_LSB=12 and PIFO_RANK_MSB=30.
- The FSM state enum.
REQ-030 The output register stage SHALL be the sub-module axis_pipe_reg, reusable by the output queue.

Verification
REQ-031 3-beat packet 1a/1b/1c, rank 100, oq_tready=1 -> m_axis shows 1a/1b/1c 1 cycle later, tpifo=0x80064000 on all beats, pifo_insert_en only on 1a, tlast on 1c, pkt_count=1.
REQ-032 Back-to-back packets 4a-4c (rank 50) and 5a-5c (rank 10) -> tpifo 0x80032000 then 0x8000A000, two insert pulses with no gap cycles.
REQ-033 oq_almost_full=1 at 6a, then deasserted at 6b -> all of 6a-6c dropped, drop_count=1; the next packet 7a-7c (rank 10) is forwarded.
REQ-034 Single-beat packet, rank 0 -> one output beat with insert_en=1, tlast=1 and tpifo=0x80000000.
REQ-035 oq_tready=0 for 3 cycles during beat 2d of a 6-beat packet -> s_axis_tready low for those cycles, 2d held, output order 2a-2f intact.
REQ-036 axis_resetn pulsed after beat 3b -> outputs and counters 0; the next beat is forwarded with insert_en=1.
